bp_cfg_boot_sequencer: RTL and testbench

Boot-time master for the config link. On a start pulse it performs a fixed, ordered series of config writes: freeze the core, program icache/dcache modes, stream the CCE microcode image from a ROM port, program the CCE mode, then unfreeze. It sits between the host/boot logic and the config-link write port. It replaces ad-hoc host-driven bring-up with a single handshaked sequence that reports completion and timeouts.

---
 rtl/bp_cfg_boot_sequencer.sv | 166 ++++++++++++++++
 tb/tb_bp_cfg_boot_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time config-link master: freeze, cache modes, CCE microcode stream, CCE mode, unfreeze.
// Exactly one write is outstanding at a time; completion and ack timeouts are reported.
module bp_cfg_boot_sequencer #(
  parameter int unsigned cfg_addr_width_p = 32,
  parameter int unsigned cfg_data_width_p = 64,
  parameter logic [63:0] cfg_base_addr_p  = 64'h0100_0000,
  parameter int unsigned ucode_words_p    = 256,
  parameter int unsigned timeout_p        = 1024,
  localparam int unsigned ua_w_lp = (ucode_words_p > 1) ? $clog2(ucode_words_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_v_i,
  input  logic [cfg_data_width_p-1:0] icache_mode_i,
  input  logic [cfg_data_width_p-1:0] dcache_mode_i,
  input  logic [cfg_data_width_p-1:0] cce_mode_i,
  output logic                        ucode_r_v_o,
  output logic [ua_w_lp-1:0]          ucode_addr_o,
  input  logic [cfg_data_width_p-1:0] ucode_data_i,
  output logic                        cfg_v_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,
  input  logic                        cfg_ack_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND      = 3'd1;
  localparam logic [2:0] WAIT_ACK  = 3'd2;
  localparam logic [2:0] UCODE_RD  = 3'd3;
  localparam logic [2:0] UCODE_LAT = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;
  localparam logic [2:0] ERROR     = 3'd6;

  localparam int unsigned iw_lp = $clog2(ucode_words_p + 5);
  localparam int unsigned tw_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam logic [iw_lp-1:0] ucode_lo_lp = iw_lp'(3);
  localparam logic [iw_lp-1:0] cce_idx_lp  = iw_lp'(ucode_words_p + 3);
  localparam logic [iw_lp-1:0] last_idx_lp = iw_lp'(ucode_words_p + 4);
  localparam logic [tw_lp-1:0] tmo_last_lp = tw_lp'(timeout_p - 1);

  logic [2:0]                  state_q, state_d;
  logic [iw_lp-1:0]            idx_q, idx_d, nidx;
  logic [tw_lp-1:0]            tmo_q, tmo_d;
  logic [cfg_addr_width_p-1:0] addr_q, addr_d;
  logic [cfg_data_width_p-1:0] data_q, data_d;
  logic [cfg_data_width_p-1:0] icm_q, icm_d, dcm_q, dcm_d, ccm_q, ccm_d;
  logic [cfg_data_width_p-1:0] nxt_data;
  logic [31:0]                 nxt_off;
  logic [ua_w_lp-1:0]          uidx;

  function automatic logic [cfg_addr_width_p-1:0] cfg_addr(input logic [31:0] off);
    logic [63:0] sum;
    sum = cfg_base_addr_p + 64'(off);
    return sum[cfg_addr_width_p-1:0];
  endfunction

  assign nidx = idx_q + iw_lp'(1);
  assign uidx = ua_w_lp'(idx_q - ucode_lo_lp);

  // Offset/data of the next non-microcode write; anything not listed is the unfreeze.
  always_comb begin
    nxt_off  = 32'h0002;
    nxt_data = '0;
    if (nidx == iw_lp'(1)) begin
      nxt_off  = 32'h0022;
      nxt_data = icm_q;
    end else if (nidx == iw_lp'(2)) begin
      nxt_off  = 32'h0043;
      nxt_data = dcm_q;
    end else if (nidx == cce_idx_lp) begin
      nxt_off  = 32'h0081;
      nxt_data = ccm_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    data_d  = data_q;
    icm_d   = icm_q;
    dcm_d   = dcm_q;
    ccm_d   = ccm_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start_v_i) begin
        state_d = SEND;
        idx_d   = '0;
        icm_d   = icache_mode_i;
        dcm_d   = dcache_mode_i;
        ccm_d   = cce_mode_i;
        addr_d  = cfg_addr(32'h0002);
        data_d  = cfg_data_width_p'(1);
      end
      SEND: if (cfg_ready_i) begin
        state_d = WAIT_ACK;
        tmo_d   = '0;
      end
      WAIT_ACK: begin
        // An ack on the final timeout cycle still wins over the error.
        if (cfg_ack_i) begin
          if (idx_q == last_idx_lp) begin
            state_d = DONE;
          end else begin
            idx_d = nidx;
            if (nidx >= ucode_lo_lp && nidx < cce_idx_lp) begin
              state_d = UCODE_RD;
            end else begin
              state_d = SEND;
              addr_d  = cfg_addr(nxt_off);
              data_d  = nxt_data;
            end
          end
        end else if (timeout_p != 0 && tmo_q == tmo_last_lp) begin
          state_d = ERROR;
        end else begin
          tmo_d = tmo_q + tw_lp'(1);
        end
      end
      UCODE_RD: state_d = UCODE_LAT;
      UCODE_LAT: begin
        state_d = SEND;
        data_d  = ucode_data_i;
        addr_d  = cfg_addr(32'h8000 + 32'(uidx));
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      icm_q   <= '0;
      dcm_q   <= '0;
      ccm_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      icm_q   <= icm_d;
      dcm_q   <= dcm_d;
      ccm_q   <= ccm_d;
    end
  end

  assign cfg_v_o      = (state_q == SEND);
  assign ucode_r_v_o  = (state_q == UCODE_RD);
  assign ucode_addr_o = ucode_r_v_o ? uidx : '0;
  assign cfg_addr_o   = addr_q;
  assign cfg_data_o   = data_q;
  assign busy_o       = (state_q == SEND) || (state_q == WAIT_ACK) ||
                        (state_q == UCODE_RD) || (state_q == UCODE_LAT);
  assign done_o       = (state_q == DONE);
  assign error_o      = (state_q == ERROR);

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Randomized bench for bp_cfg_boot_sequencer: a config-target responder plus a
// write-list model built from the boot order, checked against observed handshakes.
module tb_bp_cfg_boot_sequencer;
  localparam int U = 4;
  localparam int TMO = 8;
  localparam logic [31:0] BASE = 32'h0100_0000;

  typedef struct packed { logic [31:0] a; logic [63:0] d; } wr_t;

  logic        clk = 0, rst_n = 1, start = 0;
  logic [63:0] icm = 0, dcm = 0, ccm = 0, udata = 0;
  logic        urv, cv, busy, done, err;
  logic [1:0]  uaddr;
  logic [31:0] caddr;
  logic [63:0] cdata;
  logic        crdy = 0, cack = 0;

  int total = 0, bad = 0;
  int cyc = 0, n_hs = 0, v_cnt = 0, end_cyc = 0;
  wr_t log_q[$];
  int  hs_cyc[$];
  logic [63:0] rom [U];
  logic [63:0] exp_icm, exp_dcm, exp_ccm;

  // responder knobs (written by the main process only)
  int stall_idx = -1, withhold_idx = -1, slow_idx = -1, slow_delay = 0;
  bit rnd = 0, spur_ack = 0;

  bp_cfg_boot_sequencer #(.cfg_addr_width_p(32), .cfg_data_width_p(64),
                          .ucode_words_p(U), .timeout_p(TMO)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .start_v_i(start),
    .icache_mode_i(icm), .dcache_mode_i(dcm), .cce_mode_i(ccm),
    .ucode_r_v_o(urv), .ucode_addr_o(uaddr), .ucode_data_i(udata),
    .cfg_v_o(cv), .cfg_addr_o(caddr), .cfg_data_o(cdata),
    .cfg_ready_i(crdy), .cfg_ack_i(cack),
    .busy_o(busy), .done_o(done), .error_o(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {cv, urv, busy, done, err, |caddr, |cdata, |uaddr};
  endfunction

  // Reference: the k-th write of a boot sequence, straight from the boot order.
  function automatic wr_t exp_wr(input int k);
    logic [31:0] off;
    logic [63:0] d;
    if (k == 0)          begin off = 32'h2;  d = 64'd1;   end
    else if (k == 1)     begin off = 32'h22; d = exp_icm; end
    else if (k == 2)     begin off = 32'h43; d = exp_dcm; end
    else if (k < 3 + U)  begin off = 32'h8000 + 32'(k - 3); d = rom[k-3]; end
    else if (k == 3 + U) begin off = 32'h81; d = exp_ccm; end
    else                 begin off = 32'h2;  d = 64'd0;   end
    return wr_t'{a: BASE + off, d: d};
  endfunction

  // ROM: data valid exactly one cycle after the read strobe, junk otherwise.
  logic       rv_s = 0;
  logic [1:0] ra_s = 0;
  always @(negedge clk) begin rv_s = urv; ra_s = uaddr; end
  always @(posedge clk) begin #1; udata = rv_s ? rom[ra_s] : {$urandom, $urandom}; end

  // Handshake monitor plus hold-stability check while ready is low.
  logic pv_hold = 0;
  logic [31:0] pa = 0;
  logic [63:0] pd = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pv_hold) begin
        chk("hold_v", cv, 1);
        chk("hold_addr", caddr, pa);
        chk("hold_data", cdata, pd);
      end
      if (cv) v_cnt++;
      if (cv && crdy) begin
        log_q.push_back(wr_t'{a: caddr, d: cdata});
        hs_cyc.push_back(cyc);
        n_hs++;
      end
      pv_hold = cv && !crdy;
      pa = caddr;
      pd = cdata;
    end else pv_hold = 0;
  end

  // Config target: drives ready and ack just after each edge.
  int seen_hs = 0, ack_wait = -1, stall_left = 0, rw = 0;
  bit in_send = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      seen_hs = n_hs; ack_wait = -1; in_send = 0; stall_left = 0;
      cack = 0; crdy = 0;
    end else begin
      if (n_hs != seen_hs) begin
        seen_hs = n_hs;
        rw = log_q.size() - 1;
        if (rw == withhold_idx) ack_wait = -1;
        else if (rw == slow_idx) ack_wait = slow_delay;
        else ack_wait = rnd ? int'($urandom_range(0, 3)) : 0;
      end
      cack = 0;
      if (ack_wait == 0) begin cack = 1; ack_wait = -1; end
      else if (ack_wait > 0) ack_wait--;
      if (spur_ack && cv && $urandom_range(0, 1) == 1) cack = 1;
      if (!cv) begin
        in_send = 0;
        crdy = 1'($urandom_range(0, 1));
      end else begin
        if (!in_send) begin
          in_send = 1;
          rw = log_q.size();
          stall_left = (rw == stall_idx) ? 7 : (rnd ? int'($urandom_range(0, 3)) : 0);
        end
        crdy = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
    end
  end

  task automatic set_data();
    exp_icm = {$urandom, $urandom};
    exp_dcm = {$urandom, $urandom};
    exp_ccm = {$urandom, $urandom};
    for (int i = 0; i < U; i++) rom[i] = {$urandom, $urandom};
    icm = exp_icm; dcm = exp_dcm; ccm = exp_ccm;
  endtask

  // Pulse start, then scramble the mode inputs to prove they were captured.
  task automatic start_seq();
    log_q.delete();
    hs_cyc.delete();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    icm = {$urandom, $urandom}; dcm = {$urandom, $urandom}; ccm = {$urandom, $urandom};
  endtask

  // lat = edges from the accepting edge to DONE/ERROR entry.
  task automatic run(output int lat, input bit spur_start);
    start_seq();
    lat = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start = 0;
      if (done || err) begin lat = k; break; end
      if (spur_start && busy && $urandom_range(0, 3) == 0) start = 1;
    end
    end_cyc = cyc;
    if (lat < 0) chk("run_budget", 0, 1);
  endtask

  task automatic check_log(input int n);
    wr_t e;
    chk("log_count", log_q.size(), n);
    for (int k = 0; k < n && k < log_q.size(); k++) begin
      e = exp_wr(k);
      chk($sformatf("wr%0d_addr", k), log_q[k].a, e.a);
      chk($sformatf("wr%0d_data", k), log_q[k].d, e.d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat, v0;
    for (int i = 0; i < U; i++) rom[i] = '0;
    #2 rst_n = 0;
    #1 chk("reset_outs", outs(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_outs", outs(), 0);

    // best case: ready always, ack one cycle after handshake
    set_data();
    run(lat, 0);
    chk("best_latency", lat, 10 + 4 * U);
    chk("best_done", {done, err, busy}, 3'b100);
    check_log(U + 5);

    // ready held low 7 cycles on the dcache write
    stall_idx = 2;
    set_data();
    run(lat, 0);
    stall_idx = -1;
    chk("stall_done", done, 1);
    chk("stall_gap", hs_cyc[2] - hs_cyc[1], 9);
    check_log(U + 5);

    // ack withheld on ucode word 2 -> timeout
    withhold_idx = 5;
    set_data();
    run(lat, 0);
    withhold_idx = -1;
    chk("tmo_state", {done, err, busy}, 3'b010);
    chk("tmo_cycles", end_cyc - hs_cyc[5] - 1, TMO);
    check_log(6);
    v0 = v_cnt;
    repeat (20) @(negedge clk);
    chk("no_v_after_err", v_cnt - v0, 0);
    chk("err_held", err, 1);
    set_data();
    run(lat, 0);
    chk("rerun_done", {done, err}, 2'b10);
    check_log(U + 5);

    // random stalls/ack delays, spurious starts while busy, acks during SEND
    for (int it = 0; it < 3; it++) begin
      rnd = 1; spur_ack = 1;
      set_data();
      run(lat, 1);
      chk("spur_done", {done, err}, 2'b10);
      check_log(U + 5);
    end
    rnd = 0; spur_ack = 0;

    // reset during WAIT_ACK of ucode word 1
    withhold_idx = 4;
    set_data();
    start_seq();
    for (int k = 0; k < 200 && log_q.size() < 5; k++) @(negedge clk);
    chk("pre_reset_writes", log_q.size(), 5);
    @(negedge clk);
    #2 rst_n = 0;
    #1 chk("midreset_outs", outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    withhold_idx = -1;
    v0 = v_cnt;
    repeat (10) @(negedge clk);
    chk("post_reset_no_v", v_cnt - v0, 0);
    chk("post_reset_outs", outs(), 0);
    set_data();
    run(lat, 0);
    chk("post_reset_run", {done, err}, 2'b10);
    check_log(U + 5);

    // ack on the exact timeout cycle wins
    slow_idx = 6; slow_delay = TMO - 1;
    set_data();
    run(lat, 0);
    slow_idx = -1;
    chk("edge_ack_state", {done, err}, 2'b10);
    chk("edge_ack_gap", hs_cyc[7] - hs_cyc[6], TMO + 1);
    check_log(U + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
